// File: rtl/alu_result_checker.sv
// Output-side monitor for the 8-bit ALU. Recomputes each accepted tuple's result one
// stage later, keeps saturating pass/fail counts and captures the first mismatching tuple.
module alu_result_checker #(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [2:0]       opcode,
  input  logic [7:0]       op,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic [7:0]       err_a,
  output logic [7:0]       err_b,
  output logic [2:0]       err_opcode,
  output logic [7:0]       err_got,
  output logic [7:0]       err_exp,
  output logic             halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;

  logic             stage_valid_q, stage_valid_d;
  logic [7:0]       stage_a_q, stage_a_d;
  logic [7:0]       stage_b_q, stage_b_d;
  logic [2:0]       stage_opcode_q, stage_opcode_d;
  logic [7:0]       stage_got_q, stage_got_d;
  logic [7:0]       stage_exp_q, stage_exp_d;

  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;

  logic             mismatch_q, mismatch_d;
  logic [7:0]       err_a_q, err_a_d;
  logic [7:0]       err_b_q, err_b_d;
  logic [2:0]       err_opcode_q, err_opcode_d;
  logic [7:0]       err_got_q, err_got_d;
  logic [7:0]       err_exp_q, err_exp_d;

  logic             accept;
  logic             stage_hit;
  logic             stage_miss;
  logic [7:0]       exp_val;

  // Golden 8-bit result; carries and borrows fall off the top.
  function automatic logic [7:0] calc_expected(input logic [2:0] opc,
                                               input logic [7:0] x,
                                               input logic [7:0] y);
    logic [7:0] r;
    case (opc)
      3'd0:    r = x + y;
      3'd1:    r = x - y;
      3'd2:    r = x & y;
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = ~x;
      3'd6:    r = {x[6:0], 1'b0};
      3'd7:    r = {1'b0, x[7:1]};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    in_ready   = (state_q == ST_RUN) && !clear;
    accept     = in_valid && in_ready;
    exp_val    = calc_expected(opcode, a, b);
    stage_hit  = stage_valid_q && (stage_got_q == stage_exp_q);
    stage_miss = stage_valid_q && (stage_got_q != stage_exp_q);
  end

  // Stage fields only load on accept, so unknown data on idle cycles never reaches outputs.
  always_comb begin
    state_d        = state_q;
    stage_valid_d  = accept;
    stage_a_d      = stage_a_q;
    stage_b_d      = stage_b_q;
    stage_opcode_d = stage_opcode_q;
    stage_got_d    = stage_got_q;
    stage_exp_d    = stage_exp_q;
    pass_d         = pass_q;
    fail_d         = fail_q;
    mismatch_d     = mismatch_q;
    err_a_d        = err_a_q;
    err_b_d        = err_b_q;
    err_opcode_d   = err_opcode_q;
    err_got_d      = err_got_q;
    err_exp_d      = err_exp_q;

    if (clear) begin
      state_d       = ST_RUN;
      stage_valid_d = 1'b0;
      pass_d        = '0;
      fail_d        = '0;
      mismatch_d    = 1'b0;
      err_a_d       = 8'h00;
      err_b_d       = 8'h00;
      err_opcode_d  = 3'd0;
      err_got_d     = 8'h00;
      err_exp_d     = 8'h00;
    end else begin
      if (stage_hit && (pass_q != CNT_MAX)) begin
        pass_d = pass_q + 1'b1;
      end

      if (stage_miss) begin
        if (fail_q != CNT_MAX) begin
          fail_d = fail_q + 1'b1;
        end
        if (!mismatch_q) begin
          mismatch_d   = 1'b1;
          err_a_d      = stage_a_q;
          err_b_d      = stage_b_q;
          err_opcode_d = stage_opcode_q;
          err_got_d    = stage_got_q;
          err_exp_d    = stage_exp_q;
        end
        if (STOP_ON_ERR) begin
          state_d = ST_HALT;
        end
      end

      if (accept) begin
        stage_a_d      = a;
        stage_b_d      = b;
        stage_opcode_d = opcode;
        stage_got_d    = op;
        stage_exp_d    = exp_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      stage_valid_q  <= 1'b0;
      stage_a_q      <= 8'h00;
      stage_b_q      <= 8'h00;
      stage_opcode_q <= 3'd0;
      stage_got_q    <= 8'h00;
      stage_exp_q    <= 8'h00;
      pass_q         <= '0;
      fail_q         <= '0;
      mismatch_q     <= 1'b0;
      err_a_q        <= 8'h00;
      err_b_q        <= 8'h00;
      err_opcode_q   <= 3'd0;
      err_got_q      <= 8'h00;
      err_exp_q      <= 8'h00;
    end else begin
      state_q        <= state_d;
      stage_valid_q  <= stage_valid_d;
      stage_a_q      <= stage_a_d;
      stage_b_q      <= stage_b_d;
      stage_opcode_q <= stage_opcode_d;
      stage_got_q    <= stage_got_d;
      stage_exp_q    <= stage_exp_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      mismatch_q     <= mismatch_d;
      err_a_q        <= err_a_d;
      err_b_q        <= err_b_d;
      err_opcode_q   <= err_opcode_d;
      err_got_q      <= err_got_d;
      err_exp_q      <= err_exp_d;
    end
  end

  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign mismatch   = mismatch_q;
  assign err_a      = err_a_q;
  assign err_b      = err_b_q;
  assign err_opcode = err_opcode_q;
  assign err_got    = err_got_q;
  assign err_exp    = err_exp_q;
  assign halted     = (state_q == ST_HALT);

endmodule
